// File: rtl/microsequencer.sv
`default_nettype none
// ============================================================================
// Module   : microsequencer
// Purpose  : T-state counter, microcode ROM addressing and microinstruction
//            mux with hardwired fetch steps, plus the run/halt/single-step
//            state machine and stall handling.
// Revision : 1.0  initial release
// ============================================================================
module microsequencer #(
  parameter int TBITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_bar,
  input  logic [7:0]            opcode,
  input  logic [15:0]           rom_data,
  input  logic                  RT,
  input  logic                  stall,
  input  logic                  halt_req,
  input  logic                  step,
  output logic [15:0]           uinstr,
  output logic [8+TBITS-1:0]    rom_addr,
  output logic [TBITS-1:0]      T,
  output logic                  halted,
  output logic                  instr_start
);

  // Hardwired fetch microinstructions and the idle word.
  localparam logic [15:0] FETCH0 = 16'h8040;
  localparam logic [15:0] FETCH1 = 16'hB480;
  localparam logic [15:0] NOP    = 16'hF000;

  localparam logic [TBITS-1:0] T_ZERO = '0;
  localparam logic [TBITS-1:0] T_ONE  = TBITS'(1);
  localparam logic [TBITS-1:0] T_LAST = '1;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_STEP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [TBITS-1:0]   t_q, t_d;
  logic               w_nop;
  logic               w_boundary;

  // A cycle is idle when halted or stalled; an idle cycle has no side effects.
  assign w_nop = (state_q == S_HALTED) || stall;

  // Boundary: the active microinstruction ends the instruction, either by RT
  // or by running off the last T-state. RT is ignored while idling.
  assign w_boundary = !w_nop && (RT || (t_q == T_LAST));

  assign T           = t_q;
  assign rom_addr    = {opcode, t_q};
  assign halted      = (state_q == S_HALTED);
  assign instr_start = (t_q == T_ZERO) && (state_q != S_HALTED) && !stall;

  // Microinstruction mux: idle word, hardwired fetch, or ROM word.
  always_comb begin
    uinstr = rom_data;
    if (w_nop) begin
      uinstr = NOP;
    end else if (t_q == T_ZERO) begin
      uinstr = FETCH0;
    end else if (t_q == T_ONE) begin
      uinstr = FETCH1;
    end
  end

  // Next T-state: hold when idle, restart at a boundary, else advance.
  always_comb begin
    t_d = t_q;
    if (w_nop) begin
      t_d = t_q;
    end else if (w_boundary) begin
      t_d = T_ZERO;
    end else begin
      t_d = t_q + T_ONE;
    end
  end

  // Run/halt/step next-state logic; halts only take effect at boundaries so
  // the running instruction always completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (w_boundary && halt_req) begin
          state_d = S_HALTED;
        end
      end
      S_HALTED: begin
        if (step) begin
          state_d = S_STEP;
        end else if (!halt_req) begin
          state_d = S_RUN;
        end
      end
      S_STEP: begin
        if (w_boundary) begin
          state_d = halt_req ? S_HALTED : S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // State and T-counter registers; reset restarts at T0 in RUN.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q <= S_RUN;
      t_q     <= T_ZERO;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_microsequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_microsequencer
// Purpose  : Self-checking bench for microsequencer (table vectors, queue
//            scoreboard, hand-written reset sequences).
// Revision : 1.0  initial release
// ============================================================================
module tb_microsequencer;

  localparam int TBITS = 3;

  logic               clk;
  logic               reset_bar;
  logic [7:0]         opcode;
  logic [15:0]        rom_data;
  logic               RT;
  logic               stall;
  logic               halt_req;
  logic               step;
  logic [15:0]        uinstr;
  logic [8+TBITS-1:0] rom_addr;
  logic [TBITS-1:0]   T;
  logic               halted;
  logic               instr_start;
  logic               rt_force;

  int total;
  int bad;

  typedef struct {
    logic        st;
    logic        hr;
    logic        sp;
    logic [15:0] rom;
    logic        rtf;
    logic [2:0]  t;
    logic [15:0] ui;
    logic        hl;
    logic        is;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  microsequencer #(.TBITS(TBITS)) dut (
    .clk         (clk),
    .reset_bar   (reset_bar),
    .opcode      (opcode),
    .rom_data    (rom_data),
    .RT          (RT),
    .stall       (stall),
    .halt_req    (halt_req),
    .step        (step),
    .uinstr      (uinstr),
    .rom_addr    (rom_addr),
    .T           (T),
    .halted      (halted),
    .instr_start (instr_start)
  );

  // Control-decoder stand-in: RT decoded from bit 11, plus a forcing term.
  assign RT = uinstr[11] | rt_force;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic st, input logic hr, input logic sp,
                              input logic [15:0] rom, input logic rtf,
                              input logic [2:0] t, input logic [15:0] ui,
                              input logic hl, input logic is);
    vec_t v;
    v.st = st; v.hr = hr; v.sp = sp; v.rom = rom; v.rtf = rtf;
    v.t = t; v.ui = ui; v.hl = hl; v.is = is;
    return v;
  endfunction

  task automatic check1(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one row, score it mid-cycle, then advance to just after the next edge.
  task automatic cyc(input vec_t v, input int idx);
    vec_t e;
    logic [10:0] exp_addr;
    stall    = v.st;
    halt_req = v.hr;
    step     = v.sp;
    rom_data = v.rom;
    rt_force = v.rtf;
    exp_q.push_back(v);
    #3;
    e = exp_q.pop_front();
    exp_addr = {opcode, e.t};
    total++;
    if (T !== e.t || uinstr !== e.ui || halted !== e.hl ||
        instr_start !== e.is || rom_addr !== exp_addr) begin
      bad++;
      $display("FAIL row%0d: got T=%0d ui=%h hlt=%b is=%b addr=%h expected T=%0d ui=%h hlt=%b is=%b addr=%h",
               idx, T, uinstr, halted, instr_start, rom_addr,
               e.t, e.ui, e.hl, e.is, exp_addr);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0; bad = 0;
    reset_bar = 1'b0; opcode = 8'h12; rom_data = 16'h0000;
    stall = 0; halt_req = 0; step = 0; rt_force = 0;

    // short instructions
    tbl.push_back(mk(0,0,0,16'h0000,0,3'd0,16'h8040,0,1));
    tbl.push_back(mk(0,0,0,16'h0000,0,3'd1,16'hB480,0,0));
    tbl.push_back(mk(0,0,0,16'h0800,0,3'd2,16'h0800,0,0));
    tbl.push_back(mk(0,0,0,16'h0000,0,3'd0,16'h8040,0,1));
    tbl.push_back(mk(0,0,0,16'h0000,0,3'd1,16'hB480,0,0));
    tbl.push_back(mk(0,0,0,16'h0800,0,3'd2,16'h0800,0,0));
    // wrap through all T-states
    tbl.push_back(mk(0,0,0,16'h0001,0,3'd0,16'h8040,0,1));
    tbl.push_back(mk(0,0,0,16'h0001,0,3'd1,16'hB480,0,0));
    for (int k = 2; k < 8; k++)
      tbl.push_back(mk(0,0,0,16'h0001,0,3'(k),16'h0001,0,0));
    // stall at T1 for two cycles
    tbl.push_back(mk(0,0,0,16'h0000,0,3'd0,16'h8040,0,1));
    tbl.push_back(mk(1,0,0,16'h0000,0,3'd1,16'hF000,0,0));
    tbl.push_back(mk(1,0,0,16'h0000,0,3'd1,16'hF000,0,0));
    tbl.push_back(mk(0,0,0,16'h0000,0,3'd1,16'hB480,0,0));
    tbl.push_back(mk(0,0,0,16'h0800,0,3'd2,16'h0800,0,0));
    // stall at T0 suppresses instr_start; stall beats RT at T2
    tbl.push_back(mk(1,0,0,16'h0000,0,3'd0,16'hF000,0,0));
    tbl.push_back(mk(0,0,0,16'h0000,0,3'd0,16'h8040,0,1));
    tbl.push_back(mk(0,0,0,16'h0000,0,3'd1,16'hB480,0,0));
    tbl.push_back(mk(1,0,0,16'h0800,1,3'd2,16'hF000,0,0));
    tbl.push_back(mk(0,0,0,16'h0800,0,3'd2,16'h0800,0,0));
    // halt requested mid-instruction, then single step
    tbl.push_back(mk(0,0,0,16'h0000,0,3'd0,16'h8040,0,1));
    tbl.push_back(mk(0,0,0,16'h0000,0,3'd1,16'hB480,0,0));
    tbl.push_back(mk(0,1,0,16'h0001,0,3'd2,16'h0001,0,0));
    tbl.push_back(mk(0,1,0,16'h0001,0,3'd3,16'h0001,0,0));
    tbl.push_back(mk(0,1,0,16'h0800,0,3'd4,16'h0800,0,0));
    tbl.push_back(mk(0,1,0,16'h0000,0,3'd0,16'hF000,1,0));
    tbl.push_back(mk(0,1,0,16'h0000,0,3'd0,16'hF000,1,0));
    tbl.push_back(mk(0,1,1,16'h0000,0,3'd0,16'hF000,1,0));
    tbl.push_back(mk(0,1,0,16'h0000,0,3'd0,16'h8040,0,1));
    tbl.push_back(mk(0,1,1,16'h0000,0,3'd1,16'hB480,0,0));
    tbl.push_back(mk(0,1,0,16'h0001,0,3'd2,16'h0001,0,0));
    tbl.push_back(mk(0,1,0,16'h0800,0,3'd3,16'h0800,0,0));
    tbl.push_back(mk(0,1,0,16'h0000,0,3'd0,16'hF000,1,0));
    tbl.push_back(mk(0,0,0,16'h0000,0,3'd0,16'hF000,1,0));
    // resume, RT on the last T-state gives a single boundary
    tbl.push_back(mk(0,0,0,16'h0001,0,3'd0,16'h8040,0,1));
    tbl.push_back(mk(0,0,0,16'h0001,0,3'd1,16'hB480,0,0));
    for (int k = 2; k < 7; k++)
      tbl.push_back(mk(0,0,0,16'h0001,0,3'(k),16'h0001,0,0));
    tbl.push_back(mk(0,0,0,16'h0800,0,3'd7,16'h0800,0,0));
    // step wins over halt_req=0 while halted
    tbl.push_back(mk(0,1,0,16'h0000,0,3'd0,16'h8040,0,1));
    tbl.push_back(mk(0,1,0,16'h0000,0,3'd1,16'hB480,0,0));
    tbl.push_back(mk(0,1,0,16'h0800,0,3'd2,16'h0800,0,0));
    tbl.push_back(mk(0,0,1,16'h0000,0,3'd0,16'hF000,1,0));
    tbl.push_back(mk(0,0,0,16'h0000,0,3'd0,16'h8040,0,1));
    tbl.push_back(mk(0,0,0,16'h0000,0,3'd1,16'hB480,0,0));
    tbl.push_back(mk(0,0,0,16'h0800,0,3'd2,16'h0800,0,0));
    tbl.push_back(mk(0,0,0,16'h0000,0,3'd0,16'h8040,0,1));

    // Reset with T mid-count.
    repeat (2) @(posedge clk);
    #1 reset_bar = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check1("pre_reset_T", 16'(T), 16'd3);
    reset_bar = 1'b0;
    #1;
    check1("rst_T", 16'(T), 16'd0);
    check1("rst_uinstr", uinstr, 16'h8040);
    check1("rst_halted", 16'(halted), 16'd0);
    check1("rst_instr_start", 16'(instr_start), 16'd1);
    check1("rst_rom_addr", 16'(rom_addr), 16'h0090);
    @(posedge clk);
    #1 reset_bar = 1'b1;

    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i], i);

    // Reset during a single-step instruction at T3.
    cyc(mk(0,1,0,16'h0000,0,3'd1,16'hB480,0,0), 100);
    cyc(mk(0,1,0,16'h0800,0,3'd2,16'h0800,0,0), 101);
    cyc(mk(0,1,1,16'h0000,0,3'd0,16'hF000,1,0), 102);
    cyc(mk(0,1,0,16'h0000,0,3'd0,16'h8040,0,1), 103);
    cyc(mk(0,1,0,16'h0001,0,3'd1,16'hB480,0,0), 104);
    cyc(mk(0,1,0,16'h0001,0,3'd2,16'h0001,0,0), 105);
    check1("step_T3", 16'(T), 16'd3);
    reset_bar = 1'b0;
    #1;
    check1("step_rst_T", 16'(T), 16'd0);
    check1("step_rst_halted", 16'(halted), 16'd0);
    check1("step_rst_uinstr", uinstr, 16'h8040);
    @(posedge clk);
    #1 reset_bar = 1'b1;
    halt_req = 1'b0;
    cyc(mk(0,0,0,16'h0000,0,3'd0,16'h8040,0,1), 110);
    cyc(mk(0,0,0,16'h0000,0,3'd1,16'hB480,0,0), 111);
    cyc(mk(0,0,0,16'h0800,0,3'd2,16'h0800,0,0), 112);
    cyc(mk(0,0,0,16'h0000,0,3'd0,16'h8040,0,1), 113);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
